// File: rtl/hazard_ctrl_pkg.sv
// ============================================================================
// Module : hazard_ctrl_pkg
// Desc   : Shared types and opcode constants for the decode hazard controller
// Rev    : 1.0
// ============================================================================
`default_nettype none

package hazard_ctrl_pkg;

    typedef logic [31:0] instr_t;

    typedef enum logic [1:0] {
        ID_FWD_RF  = 2'd0,
        ID_FWD_EX  = 2'd1,
        ID_FWD_MEM = 2'd2,
        ID_FWD_WB  = 2'd3
    } id_fwd_sel_t;

    typedef struct packed {
        logic [4:0] rd;
        logic       wr;
        logic       ld;
    } sb_entry_t;

    localparam sb_entry_t SB_EMPTY = '0;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

endpackage

`default_nettype wire

// File: rtl/hazard_ctrl_reg_use_decode.sv
// ============================================================================
// Module : reg_use_decode
// Desc   : Opcode-level register usage flags and register fields for ID
// Rev    : 1.0
// ============================================================================
`default_nettype none

module reg_use_decode
    import hazard_ctrl_pkg::*;
(
    input  instr_t     instr,
    output logic       uses_rs1,
    output logic       uses_rs2,
    output logic       writes_rd,
    output logic       is_load,
    output logic [4:0] rs1,
    output logic [4:0] rs2,
    output logic [4:0] rd
);

    logic unused_bits;
    assign unused_bits = ^{instr[31:25], instr[14:12]};

    assign rs1 = instr[19:15];
    assign rs2 = instr[24:20];
    assign rd  = instr[11:7];

    always_comb begin
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        writes_rd = 1'b0;
        is_load   = 1'b0;
        case (instr[6:0])
            OPC_OP: begin
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
                writes_rd = 1'b1;
            end
            OPC_OP_IMM, OPC_JALR: begin
                uses_rs1  = 1'b1;
                writes_rd = 1'b1;
            end
            OPC_LOAD: begin
                uses_rs1  = 1'b1;
                writes_rd = 1'b1;
                is_load   = 1'b1;
            end
            OPC_STORE, OPC_BRANCH: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OPC_LUI, OPC_AUIPC, OPC_JAL: begin
                writes_rd = 1'b1;
            end
            default: begin
                uses_rs1 = 1'b0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module : hazard_ctrl
// Desc   : EX/MEM/WB scoreboard, forwarding selects, load-use stall and flush
// Rev    : 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  instr_t           id_instr,
    input  logic             id_valid,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output id_fwd_sel_t      fwd_rs1,
    output id_fwd_sel_t      fwd_rs2,
    output logic             stall_if,
    output logic             stall_id,
    output logic             bubble_ex,
    output logic             flush_if,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic       uses_rs1, uses_rs2, writes_rd, is_load;
    logic [4:0] rs1, rs2, rd;
    logic       load_use;

    sb_entry_t        sb_ex_q, sb_ex_d, sb_mem_q, sb_mem_d, sb_wb_q, sb_wb_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    reg_use_decode u_dec (
        .instr     (id_instr),
        .uses_rs1  (uses_rs1),
        .uses_rs2  (uses_rs2),
        .writes_rd (writes_rd),
        .is_load   (is_load),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd)
    );

    function automatic logic ld_hit(input logic used, input logic [4:0] rs, input sb_entry_t ex);
        return used && (rs != 5'd0) && ex.wr && ex.ld && (ex.rd == rs);
    endfunction

    // Youngest writer wins; a load still in EX masks older copies of that register.
    function automatic id_fwd_sel_t fwd_sel(input logic used, input logic [4:0] rs,
                                            input sb_entry_t ex, input sb_entry_t mem,
                                            input sb_entry_t wb);
        if (!used || rs == 5'd0)         return ID_FWD_RF;
        if (ex.wr && ex.rd == rs)        return ex.ld ? ID_FWD_RF : ID_FWD_EX;
        if (mem.wr && mem.rd == rs)      return ID_FWD_MEM;
        if (wb.wr && wb.rd == rs)        return ID_FWD_WB;
        return ID_FWD_RF;
    endfunction

    always_comb begin
        load_use  = id_valid && (ld_hit(uses_rs1, rs1, sb_ex_q) || ld_hit(uses_rs2, rs2, sb_ex_q));
        fwd_rs1   = ID_FWD_RF;
        fwd_rs2   = ID_FWD_RF;
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        bubble_ex = 1'b0;
        flush_if  = 1'b0;
        if (!rst) begin
            if (id_valid) begin
                fwd_rs1 = fwd_sel(uses_rs1, rs1, sb_ex_q, sb_mem_q, sb_wb_q);
                fwd_rs2 = fwd_sel(uses_rs2, rs2, sb_ex_q, sb_mem_q, sb_wb_q);
            end
            stall_if  = mem_busy || load_use;
            stall_id  = mem_busy || load_use;
            bubble_ex = load_use && !mem_busy;
            flush_if  = branch_taken && id_valid && !(mem_busy || load_use);
        end
    end

    always_comb begin
        sb_ex_d     = sb_ex_q;
        sb_mem_d    = sb_mem_q;
        sb_wb_d     = sb_wb_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!mem_busy) begin
            sb_wb_d  = sb_mem_q;
            sb_mem_d = sb_ex_q;
            if (id_valid && !bubble_ex) begin
                sb_ex_d.rd = rd;
                sb_ex_d.wr = writes_rd && (rd != 5'd0);
                sb_ex_d.ld = is_load;
            end else begin
                sb_ex_d = SB_EMPTY;
            end
            if (bubble_ex) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
        end
        if (flush_if) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_ex_q     <= SB_EMPTY;
            sb_mem_q    <= SB_EMPTY;
            sb_wb_q     <= SB_EMPTY;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            sb_ex_q     <= sb_ex_d;
            sb_mem_q    <= sb_mem_d;
            sb_wb_q     <= sb_wb_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module : tb_hazard_ctrl
// Desc   : Directed bench for hazard_ctrl with an in-bench pipeline model
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    instr_t      id_instr;
    logic        id_valid, branch_taken, mem_busy;
    id_fwd_sel_t fwd_rs1, fwd_rs2;
    logic        stall_if, stall_id, bubble_ex, flush_if;
    logic [31:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    // Model: age 0 = EX, 1 = MEM, 2 = WB; select code for a hit at age a is a+1.
    int          m_rd [3];
    bit          m_wr [3];
    bit          m_ld [3];
    logic [31:0] m_stall, m_flush;

    hazard_ctrl #(.CNT_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_instr     (id_instr),
        .id_valid     (id_valid),
        .branch_taken (branch_taken),
        .mem_busy     (mem_busy),
        .fwd_rs1      (fwd_rs1),
        .fwd_rs2      (fwd_rs2),
        .stall_if     (stall_if),
        .stall_id     (stall_id),
        .bubble_ex    (bubble_ex),
        .flush_if     (flush_if),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    always #5 clk = ~clk;

    function automatic instr_t enc_r(input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b);
        return {7'd0, b, a, 3'b000, rd, 7'h33};
    endfunction
    function automatic instr_t enc_addi(input logic [4:0] rd, input logic [4:0] a, input logic [11:0] imm);
        return {imm, a, 3'b000, rd, 7'h13};
    endfunction
    function automatic instr_t enc_lw(input logic [4:0] rd, input logic [4:0] a);
        return {12'd0, a, 3'b010, rd, 7'h03};
    endfunction
    function automatic instr_t enc_sw(input logic [4:0] base, input logic [4:0] src);
        return {7'd0, src, base, 3'b010, 5'd0, 7'h23};
    endfunction
    function automatic instr_t enc_beq(input logic [4:0] a, input logic [4:0] b);
        return {7'd0, b, a, 3'b000, 5'd0, 7'h63};
    endfunction
    function automatic instr_t enc_lui(input logic [4:0] rd, input logic [19:0] imm);
        return {imm, rd, 7'h37};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void m_decode(input instr_t i, output bit u1, output bit u2,
                                     output bit w, output bit l);
        u1 = 0; u2 = 0; w = 0; l = 0;
        case (i[6:0])
            7'h33:               begin u1 = 1; u2 = 1; w = 1; end
            7'h13, 7'h67:        begin u1 = 1; w = 1; end
            7'h03:               begin u1 = 1; w = 1; l = 1; end
            7'h23, 7'h63:        begin u1 = 1; u2 = 1; end
            7'h37, 7'h17, 7'h6f: begin w = 1; end
            default:             begin end
        endcase
    endfunction

    function automatic int youngest(input int r);
        for (int a = 0; a < 3; a++)
            if (m_wr[a] && m_rd[a] == r) return a;
        return -1;
    endfunction

    function automatic int m_sel(input bit used, input int r);
        int a;
        if (!id_valid || !used || r == 0) return 0;
        a = youngest(r);
        if (a < 0 || (a == 0 && m_ld[0])) return 0;
        return a + 1;
    endfunction

    function automatic bit m_lu();
        bit u1, u2, w, l;
        int r1, r2;
        m_decode(id_instr, u1, u2, w, l);
        r1 = int'(id_instr[19:15]);
        r2 = int'(id_instr[24:20]);
        if (!id_valid) return 0;
        return (u1 && r1 != 0 && youngest(r1) == 0 && m_ld[0]) ||
               (u2 && r2 != 0 && youngest(r2) == 0 && m_ld[0]);
    endfunction

    task automatic compare();
        bit u1, u2, w, l, lu, stall;
        m_decode(id_instr, u1, u2, w, l);
        lu    = m_lu();
        stall = mem_busy || lu;
        chk("m_fwd_rs1", int'(fwd_rs1), m_sel(u1, int'(id_instr[19:15])));
        chk("m_fwd_rs2", int'(fwd_rs2), m_sel(u2, int'(id_instr[24:20])));
        chk("m_stall_if", int'(stall_if), int'(stall));
        chk("m_stall_id", int'(stall_id), int'(stall));
        chk("m_bubble_ex", int'(bubble_ex), int'(lu && !mem_busy));
        chk("m_flush_if", int'(flush_if), int'(branch_taken && id_valid && !stall));
        chk("m_stall_cnt", int'(stall_cnt), int'(m_stall));
        chk("m_flush_cnt", int'(flush_cnt), int'(m_flush));
    endtask

    task automatic model_step();
        bit u1, u2, w, l, lu;
        m_decode(id_instr, u1, u2, w, l);
        lu = m_lu();
        if (branch_taken && id_valid && !(mem_busy || lu)) m_flush = m_flush + 32'd1;
        if (!mem_busy) begin
            if (lu) m_stall = m_stall + 32'd1;
            for (int a = 2; a > 0; a--) begin
                m_rd[a] = m_rd[a-1]; m_wr[a] = m_wr[a-1]; m_ld[a] = m_ld[a-1];
            end
            if (lu || !id_valid) begin
                m_rd[0] = 0; m_wr[0] = 0; m_ld[0] = 0;
            end else begin
                m_rd[0] = int'(id_instr[11:7]);
                m_wr[0] = w && (id_instr[11:7] != 5'd0);
                m_ld[0] = l;
            end
        end
    endtask

    task automatic model_reset();
        for (int a = 0; a < 3; a++) begin
            m_rd[a] = 0; m_wr[a] = 0; m_ld[a] = 0;
        end
        m_stall = '0;
        m_flush = '0;
    endtask

    task automatic drive(input instr_t i, input logic v, input logic bt, input logic mb);
        id_instr = i; id_valid = v; branch_taken = bt; mem_busy = mb;
    endtask

    task automatic sample();
        @(negedge clk);
        if (!rst) compare();
    endtask

    task automatic advance();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic run(input instr_t i);
        drive(i, 1'b1, 1'b0, 1'b0);
        sample();
        advance();
    endtask

    initial begin
        model_reset();
        rst = 1'b1;
        drive(enc_r(5'd6, 5'd5, 5'd5), 1'b1, 1'b1, 1'b1);
        sample();
        chk("rst_fwd_rs1", int'(fwd_rs1), 0);
        chk("rst_fwd_rs2", int'(fwd_rs2), 0);
        chk("rst_stall_if", int'(stall_if), 0);
        chk("rst_bubble_ex", int'(bubble_ex), 0);
        chk("rst_flush_if", int'(flush_if), 0);
        chk("rst_stall_cnt", int'(stall_cnt), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // EX forward on both sources
        run(enc_addi(5'd5, 5'd0, 12'd7));
        drive(enc_r(5'd6, 5'd5, 5'd5), 1'b1, 1'b0, 1'b0);
        sample();
        chk("exfwd_rs1", int'(fwd_rs1), 1);
        chk("exfwd_rs2", int'(fwd_rs2), 1);
        chk("exfwd_stall", int'(stall_if), 0);
        advance();

        // Load-use against a taken branch
        run(enc_lw(5'd5, 5'd1));
        drive(enc_beq(5'd5, 5'd0), 1'b1, 1'b1, 1'b0);
        sample();
        chk("lu_stall_if", int'(stall_if), 1);
        chk("lu_stall_id", int'(stall_id), 1);
        chk("lu_bubble", int'(bubble_ex), 1);
        chk("lu_flush_held", int'(flush_if), 0);
        chk("lu_fwd_masked", int'(fwd_rs1), 0);
        advance();
        sample();
        chk("lu_fwd_mem", int'(fwd_rs1), 2);
        chk("lu_flush", int'(flush_if), 1);
        chk("lu_released", int'(stall_if), 0);
        advance();
        drive('0, 1'b0, 1'b0, 1'b0);
        sample();
        chk("lu_stall_cnt", int'(stall_cnt), 1);
        chk("lu_flush_cnt", int'(flush_cnt), 1);
        advance();

        // Priority across EX/MEM/WB, and x0 never forwards
        run(enc_addi(5'd3, 5'd0, 12'd1));
        drive(enc_addi(5'd3, 5'd3, 12'd2), 1'b1, 1'b0, 1'b0);
        sample();
        chk("pri_ex_single", int'(fwd_rs1), 1);
        advance();
        run(enc_addi(5'd3, 5'd3, 12'd3));
        drive(enc_r(5'd4, 5'd3, 5'd0), 1'b1, 1'b0, 1'b0);
        sample();
        chk("pri_ex_wins", int'(fwd_rs1), 1);
        chk("pri_x0_rs2", int'(fwd_rs2), 0);
        advance();
        drive(enc_r(5'd4, 5'd3, 5'd3), 1'b1, 1'b0, 1'b0);
        sample();
        chk("pri_mem", int'(fwd_rs1), 2);
        advance();
        run(enc_addi(5'd0, 5'd0, 12'd5));
        drive(enc_r(5'd8, 5'd0, 5'd0), 1'b1, 1'b0, 1'b0);
        sample();
        chk("x0_rs1", int'(fwd_rs1), 0);
        chk("x0_rs2", int'(fwd_rs2), 0);
        advance();

        // mem_busy overrides a pending load-use
        run(enc_lw(5'd9, 5'd2));
        for (int k = 0; k < 3; k++) begin
            drive(enc_r(5'd10, 5'd9, 5'd1), 1'b1, 1'b0, 1'b1);
            sample();
            chk("busy_stall_if", int'(stall_if), 1);
            chk("busy_stall_id", int'(stall_id), 1);
            chk("busy_bubble", int'(bubble_ex), 0);
            chk("busy_stall_cnt", int'(stall_cnt), 1);
            advance();
        end
        drive(enc_r(5'd10, 5'd9, 5'd1), 1'b1, 1'b0, 1'b0);
        sample();
        chk("busy_rel_bubble", int'(bubble_ex), 1);
        chk("busy_rel_stall", int'(stall_if), 1);
        advance();
        sample();
        chk("busy_rel_fwd", int'(fwd_rs1), 2);
        chk("busy_rel_nostall", int'(stall_if), 0);
        chk("busy_rel_cnt", int'(stall_cnt), 2);
        advance();

        // Opcodes without sources
        run(enc_lw(5'd7, 5'd1));
        drive(enc_lui(5'd7, 20'd5), 1'b1, 1'b0, 1'b0);
        sample();
        chk("lui_nostall", int'(stall_if), 0);
        chk("lui_fwd_rs1", int'(fwd_rs1), 0);
        chk("lui_fwd_rs2", int'(fwd_rs2), 0);
        advance();
        drive(enc_sw(5'd7, 5'd7), 1'b1, 1'b0, 1'b0);
        sample();
        chk("sw_rs1", int'(fwd_rs1), 1);
        chk("sw_rs2", int'(fwd_rs2), 1);
        advance();

        // Asynchronous reset in the middle of a load-use stall
        run(enc_lw(5'd11, 5'd1));
        drive(enc_r(5'd12, 5'd11, 5'd11), 1'b1, 1'b1, 1'b0);
        sample();
        chk("mid_stall", int'(stall_if), 1);
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        chk("arst_stall_if", int'(stall_if), 0);
        chk("arst_stall_id", int'(stall_id), 0);
        chk("arst_bubble", int'(bubble_ex), 0);
        chk("arst_flush", int'(flush_if), 0);
        chk("arst_fwd_rs1", int'(fwd_rs1), 0);
        chk("arst_stall_cnt", int'(stall_cnt), 0);
        chk("arst_flush_cnt", int'(flush_cnt), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(enc_r(5'd12, 5'd11, 5'd11), 1'b1, 1'b0, 1'b0);
        sample();
        chk("post_rst_fwd", int'(fwd_rs1), 0);
        advance();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
